imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the core's instruction fetch path. Receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word into the instruction memory write port at consecutive byte addresses starting at 0.
- Holds the CPU in reset until the whole image is written, then releases it so execution starts from PC 0.
- Sits between the host link (UART/testbench byte source) and the instruction memory write port plus the cpu `rst` input.

Parameters:
- WIDTH, 32, data/address width of the memory write port; must be 32.
- ADDR_WIDTH, 12, number of significant byte-address bits; capacity is CAP = 2^(ADDR_WIDTH-2) words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs on a rising edge where in_valid && in_ready.
- mem_we  output  1  instruction memory write strobe, one-cycle pulse.
- mem_addr  output  WIDTH  byte address of the write: 4*k, upper bits above ADDR_WIDTH are 0.
- mem_wdata  output  WIDTH  word to write.
- cpu_rst  output  1  reset to the core; 1 while loading.
- busy  output  1  frame in progress.
- done  output  1  image loaded, core released.
- error  output  1  frame rejected.
- words_loaded  output  16  count of words written this frame.

Behaviour:
- **Clock and reset.** One clock; reset is synchronous and active-high. Ports are named clk and rst.
- **Reset values.** While rst=1 and at the edge it is sampled:
  - state=LEN_LO
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_rst=1, busy=0, done=0, error=0, words_loaded=0
- **Frame format.**
  - LEN_LO byte, then LEN_HI byte: N = 16-bit word count, little-endian.
  - Then 4*N payload bytes, each word little-endian (first byte goes to bits [7:0]).
  - Then, with the optional feature only, 1 checksum byte.
- **States:** LEN_LO, LEN_HI, DATA, CHK, FLUSH, DONE, ERR.
- **in_ready** is 1 in LEN_LO, LEN_HI, DATA and CHK; 0 in FLUSH, DONE and ERR. It depends only on the state register, never combinationally on in_valid.
- **LEN_LO:** on transfer, latch the low byte, set busy=1, go to LEN_HI.
- **LEN_HI:** on transfer, latch the high byte.
  - N > CAP: go to ERR.
  - N = 0: go to CHK if the feature is on, else FLUSH.
  - Otherwise: go to DATA.
- **DATA:**
  - A 2-bit byte counter packs bytes into a 24-bit staging register.
  - On the 4th byte of word k, the next cycle has mem_we=1, mem_addr=4*k, mem_wdata={byte3,byte2,byte1,byte0}, and words_loaded increments to k+1.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
  - In DATA a new byte may be accepted in the same cycle as mem_we.
  - After word N-1's 4th byte, go to CHK (feature on) or FLUSH.
- **FLUSH:** lasts exactly one cycle, then go to DONE. The final mem_we pulse occurs in this cycle.
- **DONE:** done=1, cpu_rst=0, busy=0. Terminal until rst.
  - done rises and cpu_rst falls on the 2nd rising edge after the final frame byte is accepted.
  - The core therefore never fetches during a write.
- **ERR:** error=1, cpu_rst=1, busy=0, in_ready=0. No further writes. Terminal until rst.
- **Reset mid-frame:** returns to LEN_LO with the reset values. Memory already written is not cleared, and the next frame overwrites it from address 0.
- **Stalls:** in_valid may drop at any point in the frame. The loader waits indefinitely, with no timeout.

Optional Feature:
- Macro name: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR over all payload bytes (length bytes excluded) is cleared at LEN_LO.
  - State CHK accepts one byte. If it equals the XOR, go to FLUSH, else go to ERR.
  - Words are already written when the check fails, but cpu_rst stays 1.
- Undefined:
  - CHK is unreachable and no XOR logic exists.
  - error is set only by N > CAP.

Test Plan:
1. **Two-word frame, continuous valid.** Send 02 00 13 05 A0 00 93 05 10 00 (feature off) -> mem_we pulses with (addr 0x0, data 0x00A00513) then (addr 0x4, data 0x00100593); words_loaded=2; done=1 and cpu_rst=0 exactly 2 edges after the last byte.
2. **Stalled stream.** Same frame with in_valid toggling 1/0 every cycle -> identical writes and values; in_ready never depends on in_valid.
3. **Empty frame.** Send 00 00 -> no mem_we; done=1 two edges after the 2nd byte; words_loaded=0.
4. **Over capacity.** With ADDR_WIDTH=12, send 01 04 (N=1025 > 1024) -> ERR; error=1; in_ready=0; cpu_rst stays 1; no mem_we.
5. **Reset mid-frame.** Assert rst after 5 payload bytes, then send a fresh 1-word frame 01 00 EF BE AD DE -> single write (0x0, 0xDEADBEEF); done=1; words_loaded=1.
6. **Checksum (IMEM_LOADER_CHECKSUM_EN).**
   - Frame 01 00 11 22 33 44 then 44 -> done=1.
   - Same frame with checksum 45 -> error=1; cpu_rst=1; word 0x44332211 was still written at 0x0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a length-prefixed byte stream into 32-bit words, writes them from address 0, then releases cpu_rst.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// LEN_LO | waiting for low byte of the word count
// LEN_HI | waiting for high byte of the word count
// DATA   | receiving payload bytes, writing one word per 4 bytes
// CHK    | waiting for the checksum byte (checksum build only)
// FLUSH  | one cycle for the final write to land before release
// DONE   | image loaded, core running
// ERR    | frame rejected, core held in reset
module imem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, FLUSH, DONE, ERR} state_t;

    localparam logic [16:0] CAP = 17'(1) << (ADDR_WIDTH - 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = FLUSH;
`endif

    state_t           state_q, state_d;
    logic [7:0]       len_lo_q;
    logic [15:0]      n_q;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      stage_q;
    logic [15:0]      word_cnt_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    logic        ready_st;
    logic        xfer;
    logic [15:0] n_in;
    logic        last_byte;

    assign ready_st  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHK);
    assign bus.in_ready = ready_st && !rst;
    assign xfer      = bus.in_valid && bus.in_ready;
    assign n_in      = {bus.in_data, len_lo_q};
    assign last_byte = (byte_cnt_q == 2'd3) && ((word_cnt_q + 16'd1) == n_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN_LO: if (xfer) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, n_in} > CAP)  state_d = ERR;
                    else if (n_in == 16'd0)  state_d = AFTER_DATA;
                    else                     state_d = DATA;
                end
            end
            DATA:   if (xfer && last_byte) state_d = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:    if (xfer) state_d = (bus.in_data == chk_q) ? FLUSH : ERR;
`else
            CHK:    state_d = FLUSH;
`endif
            FLUSH:  state_d = DONE;
            DONE:   state_d = DONE;
            ERR:    state_d = ERR;
            default: state_d = LEN_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LEN_LO;
            len_lo_q    <= '0;
            n_q         <= '0;
            byte_cnt_q  <= '0;
            stage_q     <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;
            if (state_q == LEN_LO && xfer) len_lo_q <= bus.in_data;
            if (state_q == LEN_HI && xfer) n_q <= n_in;
            if (state_q == DATA && xfer) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= WIDTH'({word_cnt_q, 2'b00});
                    mem_wdata_q <= WIDTH'({bus.in_data, stage_q});
                    word_cnt_q  <= word_cnt_q + 16'd1;
                end else begin
                    // bytes enter at the top so byte0 ends up in [7:0]
                    stage_q <= {bus.in_data, stage_q[23:8]};
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state_q == LEN_LO)            chk_q <= '0;
            else if (state_q == DATA && xfer) chk_q <= chk_q ^ bus.in_data;
`endif
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign words_loaded  = word_cnt_q;
    assign cpu_rst       = rst || (state_q != DONE);
    assign done          = !rst && (state_q == DONE);
    assign error         = !rst && (state_q == ERR);
    assign busy          = !rst && ((state_q == LEN_HI) || (state_q == DATA) ||
                                    (state_q == CHK)    || (state_q == FLUSH));
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes plus per-scenario checks.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rst, busy, done, error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader_if #(.WIDTH(32)) bus ();

    imem_loader #(.WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int          checks = 0;
    int          failures = 0;
    int          we_count = 0;
    logic [7:0]  frame_q[$];
    logic [31:0] img_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    // scoreboard: every write strobe must match the oldest expected (addr, data)
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.mem_we === 1'b1) begin
            we_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h expected none", bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic build_frame(input logic [15:0] n);
        logic [7:0] x;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        foreach (img_q[i]) begin
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(img_q[i][8*b +: 8]);
                x = x ^ img_q[i][8*b +: 8];
            end
            exp_q.push_back({32'(i * 4), img_q[i]});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(x);
`endif
    endtask

    task automatic send_bytes(input bit stall);
        foreach (frame_q[i]) begin
            bit ok;
            int t;
            if (stall) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_when_idle got %b expected 1", bus.in_ready);
                end
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            ok = 1'b0;
            t  = 0;
            while (!ok) begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk);
                #1;
                t++;
                if (!ok && t > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout got no accept expected accept of byte %0d", i);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // final byte accepted just before this: one FLUSH cycle, then DONE
    task automatic check_release(input string tag, input logic [15:0] exp_words, input int exp_we, input int we_base);
        @(negedge clk);
        checks++;
        if ({done, cpu_rst, busy} !== 3'b011) begin
            failures++;
            $display("FAIL %s_flush got done/cpu_rst/busy=%b expected 011", tag, {done, cpu_rst, busy});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({done, cpu_rst, busy, error} !== 4'b1000) begin
            failures++;
            $display("FAIL %s_done got done/cpu_rst/busy/error=%b expected 1000", tag, {done, cpu_rst, busy, error});
        end
        checks++;
        if (words_loaded !== exp_words) begin
            failures++;
            $display("FAIL %s_words got %0d expected %0d", tag, words_loaded, exp_words);
        end
        checks++;
        if ((we_count - we_base) != exp_we || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes got %0d writes, %0d pending expected %0d, 0", tag, we_count - we_base, exp_q.size(), exp_we);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.mem_we, cpu_rst, busy, done, error} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 001000", {bus.in_ready, bus.mem_we, cpu_rst, busy, done, error});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if (words_loaded !== 16'd0) begin
            failures++;
            $display("FAIL reset_words got %0d expected 0", words_loaded);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, busy, cpu_rst} !== 3'b101) begin
            failures++;
            $display("FAIL post_reset got ready/busy/cpu_rst=%b expected 101", {bus.in_ready, busy, cpu_rst});
        end
    endtask

    task automatic test_two_word(input bit stall);
        int base;
        apply_reset();
        base = we_count;
        img_q = {32'h00A00513, 32'h00100593};
        build_frame(16'd2);
        send_bytes(stall);
        check_release(stall ? "stalled" : "two_word", 16'd2, 2, base);
    endtask

    task automatic test_empty();
        int base;
        apply_reset();
        base = we_count;
        img_q.delete();
        build_frame(16'd0);
        send_bytes(1'b0);
        check_release("empty", 16'd0, 0, base);
    endtask

    task automatic test_over_cap();
        int base;
        apply_reset();
        base = we_count;
        frame_q = {8'h01, 8'h04};
        send_bytes(1'b0);
        @(negedge clk);
        checks++;
        if ({error, bus.in_ready, cpu_rst, busy, done} !== 5'b10100) begin
            failures++;
            $display("FAIL over_cap got error/ready/cpu_rst/busy/done=%b expected 10100", {error, bus.in_ready, cpu_rst, busy, done});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((we_count - base) != 0 || error !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL over_cap_hold got writes=%0d error=%b ready=%b expected 0 1 0", we_count - base, error, bus.in_ready);
        end
    endtask

    task automatic test_cap_boundary();
        apply_reset();
        frame_q = {8'h00, 8'h04};
        send_bytes(1'b0);
        @(negedge clk);
        checks++;
        if ({error, busy, bus.in_ready} !== 3'b011) begin
            failures++;
            $display("FAIL cap_exact got error/busy/ready=%b expected 011", {error, busy, bus.in_ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        apply_reset();
        base = we_count;
        frame_q = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93};
        exp_q.push_back({32'h0, 32'h00A00513});
        send_bytes(1'b0);
        @(negedge clk);
        checks++;
        if (words_loaded !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame got words=%0d busy=%b expected 1 1", words_loaded, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (words_loaded !== 16'd0 || busy !== 1'b0 || cpu_rst !== 1'b1 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got words=%0d busy=%b cpu_rst=%b we=%b expected 0 0 1 0", words_loaded, busy, cpu_rst, bus.mem_we);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        img_q = {32'hDEADBEEF};
        build_frame(16'd1);
        send_bytes(1'b0);
        check_release("reload", 16'd1, 2, base);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_ok();
        int base;
        apply_reset();
        base = we_count;
        img_q = {32'h44332211};
        build_frame(16'd1);
        checks++;
        if (frame_q[frame_q.size()-1] !== 8'h44) begin
            failures++;
            $display("FAIL chk_byte got %h expected 44", frame_q[frame_q.size()-1]);
        end
        send_bytes(1'b0);
        check_release("chk_ok", 16'd1, 1, base);
    endtask

    task automatic test_checksum_bad();
        int base;
        apply_reset();
        base = we_count;
        img_q = {32'h44332211};
        build_frame(16'd1);
        frame_q[frame_q.size()-1] = 8'h45;
        send_bytes(1'b0);
        @(negedge clk);
        checks++;
        if ({error, cpu_rst, done, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL chk_bad got error/cpu_rst/done/busy=%b expected 1100", {error, cpu_rst, done, busy});
        end
        checks++;
        if ((we_count - base) != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL chk_bad_write got %0d writes, %0d pending expected 1, 0", we_count - base, exp_q.size());
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_two_word(1'b0);
        test_two_word(1'b1);
        test_empty();
        test_over_cap();
        test_cap_boundary();
        test_reset_mid_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_ok();
        test_checksum_bad();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
